// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: ID/EX hazard sources and memory busywaits in,
// per-stage hold/bubble controls and performance counters out.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_RS1;
  logic [4:0]       ID_RS2;
  logic             ID_USES_RS1;
  logic             ID_USES_RS2;
  logic [4:0]       EX_RD;
  logic             EX_MEM_READ;
  logic             EX_BRANCH_TAKEN;
  logic             EX_MD_START;
  logic             IMEM_BUSYWAIT;
  logic             DMEM_BUSYWAIT;
  logic             PC_STALL;
  logic             IF_ID_STALL;
  logic             ID_EX_STALL;
  logic             EX_MEM_STALL;
  logic             MEM_WB_STALL;
  logic             IF_ID_FLUSH;
  logic             ID_EX_FLUSH;
  logic             EX_MEM_FLUSH;
  logic             MD_BUSY;
  logic [CNT_W-1:0] STALL_COUNT;
  logic [CNT_W-1:0] FLUSH_COUNT;

  modport master (
    output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD, EX_MEM_READ,
           EX_BRANCH_TAKEN, EX_MD_START, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
    input  PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL,
           IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MD_BUSY, STALL_COUNT, FLUSH_COUNT
  );

  modport slave (
    input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD, EX_MEM_READ,
           EX_BRANCH_TAKEN, EX_MD_START, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
    output PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL,
           IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MD_BUSY, STALL_COUNT, FLUSH_COUNT
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush scheduler for the 5-stage pipeline: memory wait > mul/div > taken
// branch > load-use, with a small FSM sequencing multi-cycle mul/div in EX.
module pipeline_hazard_controller #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input logic                        CLK,
  input logic                        RESET,
  pipeline_hazard_controller_if.slave hz
);

  localparam int MD_CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam logic MD_MULTI = (MD_LATENCY > 1);
  localparam logic [MD_CNT_W-1:0] MD_ZERO = {MD_CNT_W{1'b0}};
  localparam logic [MD_CNT_W-1:0] MD_ONE = MD_CNT_W'(1);
  localparam logic [MD_CNT_W-1:0] MD_RELOAD = (MD_LATENCY > 1) ? MD_CNT_W'(MD_LATENCY - 2) : MD_ZERO;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  md_state_e           state_r;
  md_state_e           state_nxt_s;
  logic [MD_CNT_W-1:0] md_cnt_r;
  logic [MD_CNT_W-1:0] md_cnt_nxt_s;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic [CNT_W-1:0]    flush_cnt_r;

  logic mem_wait_s;
  logic load_use_s;
  logic md_stall_s;
  logic branch_flush_s;
  logic pc_stall_s;
  logic if_id_stall_s;
  logic id_ex_stall_s;
  logic ex_mem_stall_s;
  logic mem_wb_stall_s;
  logic if_id_flush_s;
  logic id_ex_flush_s;
  logic ex_mem_flush_s;
  logic md_busy_s;

  // Hazard source decode
  always_comb begin
    mem_wait_s = hz.IMEM_BUSYWAIT | hz.DMEM_BUSYWAIT;
    load_use_s = hz.EX_MEM_READ & (hz.EX_RD != 5'd0) &
                 ((hz.ID_USES_RS1 & (hz.ID_RS1 == hz.EX_RD)) |
                  (hz.ID_USES_RS2 & (hz.ID_RS2 == hz.EX_RD)));
    md_stall_s = 1'b0;
    case (state_r)
      RUN:     md_stall_s = hz.EX_MD_START & MD_MULTI;
      MD_WAIT: md_stall_s = (md_cnt_r != MD_ZERO);
      default: md_stall_s = 1'b0;
    endcase
  end

  // Prioritised stall/flush outputs; reset forces bubbles into every stage
  always_comb begin
    pc_stall_s     = 1'b0;
    if_id_stall_s  = 1'b0;
    id_ex_stall_s  = 1'b0;
    ex_mem_stall_s = 1'b0;
    mem_wb_stall_s = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_flush_s = 1'b0;
    branch_flush_s = 1'b0;
    md_busy_s      = 1'b0;
    if (RESET) begin
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
      ex_mem_flush_s = 1'b1;
    end else begin
      md_busy_s = (state_r == MD_WAIT);
      if (mem_wait_s) begin
        pc_stall_s     = 1'b1;
        if_id_stall_s  = 1'b1;
        id_ex_stall_s  = 1'b1;
        ex_mem_stall_s = 1'b1;
        mem_wb_stall_s = 1'b1;
      end else if (md_stall_s) begin
        // Older instructions keep draining while the op sits in EX
        pc_stall_s     = 1'b1;
        if_id_stall_s  = 1'b1;
        id_ex_stall_s  = 1'b1;
        ex_mem_flush_s = 1'b1;
      end else if (hz.EX_BRANCH_TAKEN) begin
        if_id_flush_s  = 1'b1;
        id_ex_flush_s  = 1'b1;
        branch_flush_s = 1'b1;
      end else if (load_use_s) begin
        pc_stall_s     = 1'b1;
        if_id_stall_s  = 1'b1;
        id_ex_flush_s  = 1'b1;
      end else begin
        pc_stall_s     = 1'b0;
      end
    end
  end

  // Mul/div sequencing; everything freezes while a memory is busy
  always_comb begin
    state_nxt_s  = state_r;
    md_cnt_nxt_s = md_cnt_r;
    if (mem_wait_s) begin
      state_nxt_s  = state_r;
      md_cnt_nxt_s = md_cnt_r;
    end else begin
      case (state_r)
        RUN: begin
          if (hz.EX_MD_START && MD_MULTI) begin
            state_nxt_s  = MD_WAIT;
            md_cnt_nxt_s = MD_RELOAD;
          end else begin
            state_nxt_s  = RUN;
          end
        end
        MD_WAIT: begin
          if (md_cnt_r != MD_ZERO) begin
            md_cnt_nxt_s = md_cnt_r - MD_ONE;
          end else begin
            state_nxt_s  = RUN;
          end
        end
        default: begin
          state_nxt_s  = RUN;
          md_cnt_nxt_s = MD_ZERO;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r  <= RUN;
      md_cnt_r <= MD_ZERO;
    end else begin
      state_r  <= state_nxt_s;
      md_cnt_r <= md_cnt_nxt_s;
    end
  end

  // Performance counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_r <= CNT_ZERO;
      flush_cnt_r <= CNT_ZERO;
    end else begin
      if (pc_stall_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (branch_flush_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign hz.PC_STALL     = pc_stall_s;
  assign hz.IF_ID_STALL  = if_id_stall_s;
  assign hz.ID_EX_STALL  = id_ex_stall_s;
  assign hz.EX_MEM_STALL = ex_mem_stall_s;
  assign hz.MEM_WB_STALL = mem_wb_stall_s;
  assign hz.IF_ID_FLUSH  = if_id_flush_s;
  assign hz.ID_EX_FLUSH  = id_ex_flush_s;
  assign hz.EX_MEM_FLUSH = ex_mem_flush_s;
  assign hz.MD_BUSY      = md_busy_s;
  assign hz.STALL_COUNT  = stall_cnt_r;
  assign hz.FLUSH_COUNT  = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scenarios followed by random traffic, every cycle checked against
// an occupancy-based reference model of the hazard rules.
module tb_pipeline_hazard_controller;

  localparam int MD_LAT  = 4;
  localparam int CW      = 4;
  localparam int CNT_MOD = 1 << CW;

  logic clk_s   = 1'b0;
  logic reset_s = 1'b1;

  int n_cmp  = 0;
  int n_fail = 0;
  int md_age = -1;   // EX cycles already spent by the mul/div op, -1 when none
  int m_stall = 0;
  int m_flush = 0;

  pipeline_hazard_controller_if #(.CNT_W(CW)) hz ();

  pipeline_hazard_controller #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
    .CLK   (clk_s),
    .RESET (reset_s),
    .hz    (hz.slave)
  );

  always #5 clk_s = ~clk_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic mr, input logic br, input logic md,
                        input logic iw, input logic dw);
    hz.ID_RS1 = rs1; hz.ID_RS2 = rs2; hz.ID_USES_RS1 = u1; hz.ID_USES_RS2 = u2;
    hz.EX_RD = rd; hz.EX_MEM_READ = mr; hz.EX_BRANCH_TAKEN = br; hz.EX_MD_START = md;
    hz.IMEM_BUSYWAIT = iw; hz.DMEM_BUSYWAIT = dw;
  endtask

  // One clock: check at the falling edge, then advance the model on the rising edge.
  task automatic tick();
    logic [8:0] e;
    logic [8:0] obs;
    logic mw, lu, busy, fe;
    int eff;
    @(negedge clk_s);
    mw   = hz.IMEM_BUSYWAIT | hz.DMEM_BUSYWAIT;
    lu   = hz.EX_MEM_READ && (hz.EX_RD != 5'd0) &&
           ((hz.ID_USES_RS1 && hz.ID_RS1 == hz.EX_RD) || (hz.ID_USES_RS2 && hz.ID_RS2 == hz.EX_RD));
    eff  = (md_age < 0 && hz.EX_MD_START) ? 0 : md_age;
    busy = (md_age >= 1);
    fe   = 1'b0;
    // order: pc, if_id, id_ex, ex_mem, mem_wb stalls | if_id, id_ex, ex_mem flushes | md_busy
    if (reset_s)                          e = 9'b00000_111_0;
    else if (mw)                          e = {8'b11111_000, busy};
    else if (eff >= 0 && eff < MD_LAT-1)  e = {8'b11100_001, busy};
    else if (hz.EX_BRANCH_TAKEN) begin    e = {8'b00000_110, busy}; fe = 1'b1; end
    else if (lu)                          e = {8'b11000_010, busy};
    else                                  e = {8'b00000_000, busy};
    obs = {hz.PC_STALL, hz.IF_ID_STALL, hz.ID_EX_STALL, hz.EX_MEM_STALL, hz.MEM_WB_STALL,
           hz.IF_ID_FLUSH, hz.ID_EX_FLUSH, hz.EX_MEM_FLUSH, hz.MD_BUSY};
    chk("controls", {23'd0, obs}, {23'd0, e});
    chk("stall_count", {28'd0, hz.STALL_COUNT}, m_stall);
    chk("flush_count", {28'd0, hz.FLUSH_COUNT}, m_flush);
    @(posedge clk_s);
    if (reset_s) begin
      md_age = -1; m_stall = 0; m_flush = 0;
    end else begin
      if (e[8]) m_stall = (m_stall + 1) % CNT_MOD;
      if (fe)   m_flush = (m_flush + 1) % CNT_MOD;
      if (!mw && eff >= 0) begin
        md_age = eff + 1;
        if (md_age >= MD_LAT) md_age = -1;
      end
    end
    #1;
  endtask

  initial begin
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    reset_s = 1'b0;
    chk("reset_stall_count", {28'd0, hz.STALL_COUNT}, 32'd0);

    // load-use: lw x5 in EX, add reading x5 in ID -> one bubble
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    hz.EX_MEM_READ = 1'b0; hz.EX_RD = 5'd0;
    tick();
    chk("lu_stall_count", {28'd0, hz.STALL_COUNT}, 32'd1);
    set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lu_x0_no_stall", {28'd0, hz.STALL_COUNT}, 32'd1);

    // taken branch overrides load-use on rs2
    set_in(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("br_flush_count", {28'd0, hz.FLUSH_COUNT}, 32'd1);
    chk("br_stall_count", {28'd0, hz.STALL_COUNT}, 32'd1);

    // mul/div held in EX for MD_LATENCY cycles -> 3 stall cycles
    hz.EX_MD_START = 1'b1;
    repeat (4) tick();
    hz.EX_MD_START = 1'b0;
    tick();
    chk("md_stall_count", {28'd0, hz.STALL_COUNT}, 32'd4);

    // dmem busywait for 2 cycles from the 2nd MD_WAIT cycle -> 6-cycle occupancy
    hz.EX_MD_START = 1'b1;
    tick(); tick();
    hz.DMEM_BUSYWAIT = 1'b1;
    tick(); tick();
    hz.DMEM_BUSYWAIT = 1'b0;
    tick();
    chk("md_busy_after_wait", {31'd0, hz.MD_BUSY}, 32'd1);
    tick();
    hz.EX_MD_START = 1'b0;
    tick();
    chk("md_wait_stall_count", {28'd0, hz.STALL_COUNT}, 32'd9);

    // imem busywait suppresses a taken branch until it drops
    hz.IMEM_BUSYWAIT = 1'b1; hz.EX_BRANCH_TAKEN = 1'b1;
    tick(); tick();
    chk("br_held_flush_count", {28'd0, hz.FLUSH_COUNT}, 32'd1);
    hz.IMEM_BUSYWAIT = 1'b0;
    tick();
    hz.EX_BRANCH_TAKEN = 1'b0;
    tick();
    chk("br_after_wait_flush", {28'd0, hz.FLUSH_COUNT}, 32'd2);
    chk("br_after_wait_stall", {28'd0, hz.STALL_COUNT}, 32'd11);

    // reset in the middle of MD_WAIT, then a fresh op restarts the full stall
    hz.EX_MD_START = 1'b1;
    tick(); tick();
    reset_s = 1'b1;
    tick();
    reset_s = 1'b0;
    chk("rst_mid_md_busy", {31'd0, hz.MD_BUSY}, 32'd0);
    repeat (4) tick();
    hz.EX_MD_START = 1'b0;
    tick();
    chk("rst_restart_stall", {28'd0, hz.STALL_COUNT}, 32'd3);
    chk("rst_restart_flush", {28'd0, hz.FLUSH_COUNT}, 32'd0);

    // random traffic against the reference model (counters wrap at 4 bits)
    for (int i = 0; i < 3000; i++) begin
      reset_s = ($urandom_range(0, 99) < 2);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 40),
             ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 25),
             ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 8));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush scheduler for the 5-stage RV32IM pipeline.
- Drives the per-register hold (BUSYWAIT-style) and bubble-insert controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves four hazard sources:
  - load-use data hazards;
  - taken branches/jumps resolved in EX;
  - multi-cycle M-extension operations;
  - instruction/data memory busywait.
- Also keeps stall and flush event counters for performance debug.

Parameters:
- MD_LATENCY, 4: total EX cycles for a mul/div operation; must be ≥1.
- CNT_W, 32: width of the performance counters.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- ID_RS1  in  5  rs1 of instruction in ID
- ID_RS2  in  5  rs2 of instruction in ID
- ID_USES_RS1  in  1  ID instruction reads rs1
- ID_USES_RS2  in  1  ID instruction reads rs2
- EX_RD  in  5  destination reg of instruction in EX (ID/EX instruction[11:7] field)
- EX_MEM_READ  in  1  EX instruction is a load
- EX_BRANCH_TAKEN  in  1  branch/jump in EX resolved taken
- EX_MD_START  in  1  EX instruction is a mul/div op
- IMEM_BUSYWAIT  in  1  instruction memory busy
- DMEM_BUSYWAIT  in  1  data memory busy
- PC_STALL  out  1  hold PC
- IF_ID_STALL  out  1  hold IF/ID
- ID_EX_STALL  out  1  hold ID/EX
- EX_MEM_STALL  out  1  hold EX/MEM
- MEM_WB_STALL  out  1  hold MEM/WB
- IF_ID_FLUSH  out  1  load NOP into IF/ID
- ID_EX_FLUSH  out  1  load bubble (all control zero) into ID/EX
- EX_MEM_FLUSH  out  1  load bubble into EX/MEM
- MD_BUSY  out  1  FSM in MD_WAIT
- STALL_COUNT  out  CNT_W  cycles with PC_STALL=1
- FLUSH_COUNT  out  CNT_W  taken-branch flush events

Behaviour:

Reset:
- On any posedge CLK with RESET=1: state=RUN, md_cnt=0, STALL_COUNT=0, FLUSH_COUNT=0.
- While RESET=1, outputs are forced combinationally: all *_STALL=0, IF_ID_FLUSH=ID_EX_FLUSH=EX_MEM_FLUSH=1, MD_BUSY=0.
- Reset mid-operation (e.g. in MD_WAIT) aborts to RUN on that edge.

Output timing:
- Outputs are combinational (Mealy) from state, md_cnt and inputs, valid in the same cycle.
- State and counters update on posedge CLK.

FSM states: RUN, MD_WAIT.

Priority (highest first), evaluated every cycle:
1. Memory wait (mem_wait = IMEM_BUSYWAIT | DMEM_BUSYWAIT):
   - All five *_STALL=1, all *_FLUSH=0.
   - FSM state and md_cnt frozen.
   - Branch and load-use actions are suppressed; they re-evaluate once the wait ends, because the EX/ID contents are held.
2. Mul/div in progress (RUN with EX_MD_START=1 and MD_LATENCY>1, or MD_WAIT with md_cnt≠0):
   - PC_STALL=IF_ID_STALL=ID_EX_STALL=1, EX_MEM_FLUSH=1.
   - EX_MEM_STALL=MEM_WB_STALL=0, so older instructions drain.
3. Taken branch (EX_BRANCH_TAKEN=1):
   - IF_ID_FLUSH=1, ID_EX_FLUSH=1, no stalls.
   - FLUSH_COUNT increments.
   - Overrides a simultaneous load-use hazard, since the ID instruction is discarded.
4. Load-use hazard: EX_MEM_READ & EX_RD≠0 & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)):
   - PC_STALL=IF_ID_STALL=1, ID_EX_FLUSH=1.
   - Exactly one bubble per hazard; the condition clears once the load moves to MEM.
5. Otherwise all outputs are 0.

Mul/div sequencing:
- RUN & EX_MD_START & !mem_wait & MD_LATENCY>1: go to MD_WAIT, md_cnt ← MD_LATENCY−2.
- MD_WAIT & !mem_wait:
  - if md_cnt≠0: md_cnt decrements, stalls asserted;
  - if md_cnt==0: no mul/div stall is asserted that cycle, state ← RUN, and the op advances from EX.
- Total stalled cycles = MD_LATENCY−1; the op occupies EX for MD_LATENCY cycles.
- EX_MD_START is ignored in MD_WAIT, so the same op cannot re-trigger.
- MD_LATENCY=1: MD_WAIT is never entered.
- Branch or load-use conditions arising in the exit cycle are handled normally in that cycle.

Counters:
- STALL_COUNT increments each cycle PC_STALL=1 and RESET=0.
- Both counters wrap modulo 2^CNT_W.

Test Plan:
- Load-use: EX: lw x5 (EX_MEM_READ=1, EX_RD=5); ID: add reading rs1=5 → exactly 1 cycle with PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1; STALL_COUNT=1. Repeat with EX_RD=0 → no stall.
- Branch + load-use together: EX_BRANCH_TAKEN=1, EX_MEM_READ=1, EX_RD=ID_RS2=7 → IF_ID_FLUSH=ID_EX_FLUSH=1, PC_STALL=0; FLUSH_COUNT=1.
- Mul/div, MD_LATENCY=4: EX_MD_START held while the op is in EX → PC/IF_ID/ID_EX stalls and EX_MEM_FLUSH high for exactly 3 cycles; MD_BUSY high for cycles 2–4; back in RUN after 4 cycles; STALL_COUNT=3.
- Busywait during mul/div: DMEM_BUSYWAIT=1 for 2 cycles starting in the 2nd MD_WAIT cycle → all five stalls high and flushes 0 for those 2 cycles; md_cnt frozen; total op occupancy = 6 cycles.
- Busywait vs branch: IMEM_BUSYWAIT=1 with EX_BRANCH_TAKEN=1 → no flush while busy; flush fires in the first cycle after busywait drops; FLUSH_COUNT increments once.
- Reset mid-MD_WAIT: assert RESET for 1 cycle → all flushes=1 and stalls=0 during reset; counters=0 and state RUN afterwards; a fresh EX_MD_START restarts the full MD_LATENCY−1 stall.
